// File: rtl/bios_boot_loader.sv
// Boot-time copy engine: streams the BIOS ROM image into main memory, then releases the CPU.
// The ROM has one cycle of registered read latency, and the engine prefetches to hide it.
module bios_boot_loader #(
  parameter int DATA_WIDTH     = 16,
  parameter int ROM_ADDR_WIDTH = 9,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int BOOT_WORDS     = 512,
  parameter int DEST_BASE      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]     rom_q,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_we,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      cpu_hold,
  output logic [DATA_WIDTH-1:0]     checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_COPY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ROM_ADDR_WIDTH-1:0] LAST_PTR  = ROM_ADDR_WIDTH'(BOOT_WORDS - 1);
  localparam logic [ROM_ADDR_WIDTH-1:0] PTR_ONE   = ROM_ADDR_WIDTH'(1);
  localparam logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = MEM_ADDR_WIDTH'(DEST_BASE);

  state_t                      state_q, state_d;
  logic [ROM_ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0]       checksum_q, checksum_d;
  logic                        accept;

  assign accept = (state_q == S_COPY) && mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      checksum_q <= checksum_d;
    end
  end

  // Next-state: auto-boot out of IDLE; start only matters once the image is in place.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_PRIME;
      S_PRIME: state_d = S_COPY;
      S_COPY:  if (accept && (wr_ptr_q == LAST_PTR)) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_PRIME;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    checksum_d = checksum_q;
    if (state_q == S_PRIME) begin
      wr_ptr_d   = '0;
      checksum_d = '0;
    end else if (accept) begin
      wr_ptr_d   = wr_ptr_q + PTR_ONE;
      checksum_d = checksum_q + rom_q;
    end
  end

  // During COPY the ROM is addressed one word ahead only when the current word is being
  // accepted, so rom_q holds the pending word steady across a stall.
  always_comb begin
    rom_addr = '0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      S_PRIME: busy = 1'b1;
      S_COPY: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        rom_addr = mem_ready ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      default: ;
    endcase
  end

  assign mem_addr  = BASE_ADDR + MEM_ADDR_WIDTH'(wr_ptr_q);
  assign mem_wdata = rom_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_bios_boot_loader.sv
// Directed bench for bios_boot_loader: full copy, stalls, mid-copy reset, re-run and a
// small-image instance with a non-zero destination base.
module tb_bios_boot_loader;

  logic        clk = 1'b0;
  logic        reset, reset_s;
  logic        start, start_s;
  logic        mem_ready, mem_ready_s;

  logic [8:0]  rom_addr, rom_addr_s;
  logic [15:0] rom_q, rom_q_s;
  logic [15:0] mem_addr, mem_addr_s;
  logic [15:0] mem_wdata, mem_wdata_s;
  logic        mem_we, mem_we_s;
  logic        busy, busy_s, done, done_s, cpu_hold, cpu_hold_s;
  logic [15:0] checksum, checksum_s;

  logic [15:0] rom_m   [512];
  logic [15:0] rom_m_s [512];

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] got_s_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int edges;

  always #5 clk = ~clk;

  bios_boot_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
    .busy(busy), .done(done), .cpu_hold(cpu_hold), .checksum(checksum)
  );

  bios_boot_loader #(
    .BOOT_WORDS(4), .DEST_BASE(16'h0100)
  ) dut_s (
    .clk(clk), .reset(reset_s), .start(start_s),
    .rom_addr(rom_addr_s), .rom_q(rom_q_s),
    .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_we(mem_we_s), .mem_ready(mem_ready_s),
    .busy(busy_s), .done(done_s), .cpu_hold(cpu_hold_s), .checksum(checksum_s)
  );

  // Registered-output ROM models
  always @(posedge clk) begin
    rom_q   <= rom_m[rom_addr];
    rom_q_s <= rom_m_s[rom_addr_s];
  end

  // Write monitors: a write sampled here with ready high is accepted on the next edge
  always @(negedge clk) begin
    if (mem_we && mem_ready)     got_q.push_back({mem_addr, mem_wdata});
    if (mem_we_s && mem_ready_s) got_s_q.push_back({mem_addr_s, mem_wdata_s});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic build_main_exp();
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back({16'(i), 16'(i * 3)});
  endtask

  task automatic compare_main(input string tag);
    int n;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
  endtask

  task automatic wait_addr(input string tag, input logic [15:0] a);
    for (int k = 0; k < 2000; k++) begin
      if (mem_we && mem_addr == a) break;
      tick();
    end
    chk(tag, {16'h0, mem_addr}, {16'h0, a});
  endtask

  task automatic run_to_done();
    edges = 0;
    while (!done && edges < 2000) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    reset = 1'b1; reset_s = 1'b1;
    start = 1'b0; start_s = 1'b0;
    mem_ready = 1'b1; mem_ready_s = 1'b1;
    for (int i = 0; i < 512; i++) begin
      rom_m[i]   = 16'(i * 3);
      rom_m_s[i] = 16'hDEAD;
    end
    rom_m_s[0] = 16'h1234; rom_m_s[1] = 16'hABCD; rom_m_s[2] = 16'hFFFF; rom_m_s[3] = 16'h0001;

    #3;
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);

    // Full copy with mem_ready held high
    tick();
    reset = 1'b0; reset_s = 1'b0;
    tick();
    chk("prime_busy",   32'(busy),   32'd1);
    chk("prime_we",     32'(mem_we), 32'd0);
    chk("prime_hold",   32'(cpu_hold), 32'd1);
    tick();
    chk("copy0_we",    32'(mem_we),    32'd1);
    chk("copy0_addr",  32'(mem_addr),  32'd0);
    chk("copy0_wdata", 32'(mem_wdata), 32'd0);
    chk("copy0_rom",   32'(rom_addr),  32'd1);
    edges = 2;
    while (!done && edges < 2000) begin
      tick();
      edges++;
      if (edges == 5) chk("small_not_done_e5", 32'(done_s), 32'd0);
      if (edges == 6) chk("small_done_e6",     32'(done_s), 32'd1);
    end
    chk("done_edge",     32'(edges),    32'd514);
    chk("done_hold",     32'(cpu_hold), 32'd0);
    chk("done_busy",     32'(busy),     32'd0);
    chk("done_we",       32'(mem_we),   32'd0);
    chk("done_rom_addr", 32'(rom_addr), 32'd0);
    chk("done_checksum", 32'(checksum), 32'h0000FD00);
    build_main_exp();
    compare_main("run1");

    chk("small_checksum", 32'(checksum_s), 32'h0000BE01);
    chk("small_hold",     32'(cpu_hold_s), 32'd0);
    chk("small_count",    32'(got_s_q.size()), 32'd4);
    if (got_s_q.size() == 4) begin
      chk("small_w0", got_s_q[0], 32'h0100_1234);
      chk("small_w1", got_s_q[1], 32'h0101_ABCD);
      chk("small_w2", got_s_q[2], 32'h0102_FFFF);
      chk("small_w3", got_s_q[3], 32'h0103_0001);
    end

    // Re-run via start, with a stall at word 5, an ignored start, and a stall on the last word
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rerun_done", 32'(done),     32'd0);
    chk("rerun_hold", 32'(cpu_hold), 32'd1);
    chk("rerun_busy", 32'(busy),     32'd1);
    wait_addr("reach_w5", 16'd5);
    mem_ready = 1'b0;
    #1;
    chk("stall_rom_addr", 32'(rom_addr),  32'd5);
    chk("stall_wdata",    32'(mem_wdata), 32'd15);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_we", k),    32'(mem_we),    32'd1);
      chk($sformatf("stall%0d_addr", k),  32'(mem_addr),  32'd5);
      chk($sformatf("stall%0d_rom", k),   32'(rom_addr),  32'd5);
      chk($sformatf("stall%0d_wdata", k), 32'(mem_wdata), 32'd15);
    end
    mem_ready = 1'b1;
    #1;
    chk("unstall_rom_addr", 32'(rom_addr), 32'd6);
    tick();
    chk("w6_addr",  32'(mem_addr),  32'd6);
    chk("w6_wdata", 32'(mem_wdata), 32'd18);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_copy_busy", 32'(busy),     32'd1);
    chk("start_in_copy_addr", 32'(mem_addr), 32'd7);
    wait_addr("reach_last", 16'd511);
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("last_stall%0d_done", k), 32'(done),     32'd0);
      chk($sformatf("last_stall%0d_we", k),   32'(mem_we),   32'd1);
      chk($sformatf("last_stall%0d_addr", k), 32'(mem_addr), 32'd511);
      chk($sformatf("last_stall%0d_rom", k),  32'(rom_addr), 32'd511);
    end
    mem_ready = 1'b1;
    tick();
    chk("run2_done",     32'(done),     32'd1);
    chk("run2_we",       32'(mem_we),   32'd0);
    chk("run2_checksum", 32'(checksum), 32'h0000FD00);
    compare_main("run2");

    // Reset in the middle of a copy
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_addr("reach_w100", 16'd100);
    reset = 1'b1;
    #1;
    chk("midrst_we",   32'(mem_we),   32'd0);
    chk("midrst_hold", 32'(cpu_hold), 32'd1);
    chk("midrst_busy", 32'(busy),     32'd0);
    tick();
    tick();
    got_q.delete();
    reset = 1'b0;
    run_to_done();
    chk("run3_edge",     32'(edges),    32'd514);
    chk("run3_checksum", 32'(checksum), 32'h0000FD00);
    compare_main("run3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
